// File: rtl/mcif_rd_arb4_ctrl_pkg.sv
// Shared constants for the 4-client MCIF read arbiter: client count, FSM
// state encodings and the post-reset last-granted ID.
package mcif_rd_arb4_ctrl_pkg;

  localparam int MCIF_ARB_NUM = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Last-granted ID after reset; 3 makes client 0 the first in line.
  localparam logic [1:0] RST_ID = 2'd3;

  function automatic logic [MCIF_ARB_NUM-1:0] id_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/mcif_rr_sel4.sv
// Combinational round-robin selector: picks the first requester after cur_id,
// wrapping around; holds cur_id when nobody requests.
module mcif_rr_sel4
  import mcif_rd_arb4_ctrl_pkg::*;
(
  input  logic [1:0]              cur_id_i,
  input  logic [MCIF_ARB_NUM-1:0] req_i,
  output logic [1:0]              nxt_id_o
);

  logic [2*MCIF_ARB_NUM-1:0] req_dbl;
  logic [2:0]                base;
  logic [MCIF_ARB_NUM-1:0]   req_rot;
  logic [1:0]                off;

  // Rotating the doubled vector puts cur_id+1 at bit 0 so a fixed priority
  // encoder yields the offset from cur_id+1.
  assign req_dbl = {req_i, req_i};
  assign base    = {1'b0, cur_id_i} + 3'd1;
  assign req_rot = req_dbl[base +: MCIF_ARB_NUM];

  always_comb begin
    off = 2'd0;
    if (req_rot[0])      off = 2'd0;
    else if (req_rot[1]) off = 2'd1;
    else if (req_rot[2]) off = 2'd2;
    else if (req_rot[3]) off = 2'd3;
  end

  assign nxt_id_o = (|req_i) ? (cur_id_i + 2'd1 + off) : cur_id_i;

endmodule

// File: rtl/mcif_rd_arb4_ctrl.sv
// 4-client round-robin read arbiter for the MCIF: one locked transaction at a
// time, command capture and response routing. MCIF_ARB_PERF_EN adds grant counters.
module mcif_rd_arb4_ctrl
  import mcif_rd_arb4_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
`ifdef MCIF_ARB_PERF_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MCIF_ARB_NUM-1:0]        cli_req,
  input  logic [MCIF_ARB_NUM*ADDR_W-1:0] cli_addr,
  input  logic [MCIF_ARB_NUM*LEN_W-1:0]  cli_len,
  output logic [MCIF_ARB_NUM-1:0]        cli_ack,
  output logic [MCIF_ARB_NUM-1:0]        cli_rsp_vld,
  output logic                           cmd_vld,
  input  logic                           cmd_rdy,
  output logic [ADDR_W-1:0]              cmd_addr,
  output logic [LEN_W-1:0]               cmd_len,
  output logic [1:0]                     cmd_id,
  input  logic                           rsp_vld,
  input  logic                           rsp_last,
  output logic                           busy,
  output logic                           err_unexp
`ifdef MCIF_ARB_PERF_EN
  ,
  output logic [MCIF_ARB_NUM*CNT_W-1:0]  perf_gnt_cnt
`endif
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        cur_id_q, cur_id_d;
  logic [1:0]        cmd_id_q, cmd_id_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic              err_q, err_d;
  logic [1:0]        nxt_id;

  mcif_rr_sel4 u_sel (
    .cur_id_i (cur_id_q),
    .req_i    (cli_req),
    .nxt_id_o (nxt_id)
  );

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    cmd_id_d   = cmd_id_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    // Beats outside DATA are flagged but never routed nor allowed to move the FSM.
    err_d      = err_q | (rsp_vld && (state_q != ST_DATA));
    case (state_q)
      ST_IDLE: begin
        if (|cli_req) begin
          cur_id_d   = nxt_id;
          cmd_id_d   = nxt_id;
          cmd_addr_d = cli_addr[nxt_id*ADDR_W +: ADDR_W];
          cmd_len_d  = cli_len[nxt_id*LEN_W +: LEN_W];
          state_d    = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_rdy) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (rsp_vld && rsp_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_id_q   <= RST_ID;
      cmd_id_q   <= 2'd0;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      cmd_id_q   <= cmd_id_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_len_q  <= cmd_len_d;
      err_q      <= err_d;
    end
  end

  assign cmd_vld     = (state_q == ST_CMD);
  assign busy        = (state_q != ST_IDLE);
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign cmd_id      = cmd_id_q;
  assign err_unexp   = err_q;
  assign cli_ack     = (cmd_vld && cmd_rdy) ? id_onehot(cmd_id_q) : '0;
  assign cli_rsp_vld = ((state_q == ST_DATA) && rsp_vld) ? id_onehot(cmd_id_q) : '0;

`ifdef MCIF_ARB_PERF_EN
  genvar gi;
  generate
    for (gi = 0; gi < MCIF_ARB_NUM; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_q;
      // Saturating so a long run never reports a small, misleading count.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (cli_ack[gi] && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      assign perf_gnt_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mcif_rd_arb4_ctrl.sv
// Randomized + directed bench for mcif_rd_arb4_ctrl against a transaction-level
// reference model. Build with MCIF_ARB_PERF_EN to also check the grant counters.
module tb_mcif_rd_arb4_ctrl;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic [3:0]        cli_req;
  logic [4*ADDR_W-1:0] cli_addr;
  logic [4*LEN_W-1:0]  cli_len;
  logic [3:0]        cli_ack;
  logic [3:0]        cli_rsp_vld;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [1:0]        cmd_id;
  logic              rsp_vld;
  logic              rsp_last;
  logic              busy;
  logic              err_unexp;
`ifdef MCIF_ARB_PERF_EN
  logic [4*CNT_W-1:0] perf_gnt_cnt;
`endif

  mcif_rd_arb4_ctrl #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
`ifdef MCIF_ARB_PERF_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cli_req     (cli_req),
    .cli_addr    (cli_addr),
    .cli_len     (cli_len),
    .cli_ack     (cli_ack),
    .cli_rsp_vld (cli_rsp_vld),
    .cmd_vld     (cmd_vld),
    .cmd_rdy     (cmd_rdy),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_id      (cmd_id),
    .rsp_vld     (rsp_vld),
    .rsp_last    (rsp_last),
    .busy        (busy),
    .err_unexp   (err_unexp)
`ifdef MCIF_ARB_PERF_EN
    ,
    .perf_gnt_cnt(perf_gnt_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: transaction phase, owner, captured command, sticky error.
  // phase 0 = waiting for requests, 1 = command offered, 2 = receiving beats.
  int          m_phase;
  int          m_last;
  int          m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic        m_err;
  int          m_cnt [4];
  int          ack_log [$];

  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  task automatic cycle(input logic r, input logic [3:0] q, input logic [127:0] a,
                       input logic [31:0] l, input logic rdy, input logic rv, input logic rl);
    logic [3:0] e_ack, e_rsp;
    @(negedge clk);
    rst = r; cli_req = q; cli_addr = a; cli_len = l;
    cmd_rdy = rdy; rsp_vld = rv; rsp_last = rl;
    #1;
    e_ack = (m_phase == 1 && rdy) ? (4'b0001 << m_id) : 4'b0000;
    e_rsp = (m_phase == 2 && rv)  ? (4'b0001 << m_id) : 4'b0000;
    chk("busy",     busy,        m_phase != 0);
    chk("cmd_vld",  cmd_vld,     m_phase == 1);
    chk("cmd_id",   cmd_id,      m_id);
    chk("cmd_addr", cmd_addr,    m_addr);
    chk("cmd_len",  cmd_len,     m_len);
    chk("cli_ack",  cli_ack,     e_ack);
    chk("rsp_vld",  cli_rsp_vld, e_rsp);
    chk("err",      err_unexp,   m_err);
`ifdef MCIF_ARB_PERF_EN
    for (int i = 0; i < 4; i++) chk("perf", perf_gnt_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
`endif
    for (int i = 0; i < 4; i++) begin
      if (cli_ack[i]) begin
        ack_log.push_back(i);
        $display("txn grant id=%0d addr=0x%0h len=%0d", i, cmd_addr, cmd_len);
      end
    end
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_last = 3; m_id = 0; m_addr = '0; m_len = '0; m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (rv && m_phase != 2) m_err = 1'b1;
      if (m_phase == 0) begin
        if (q != 4'b0000) begin
          m_last  = rr_pick(m_last, q);
          m_id    = m_last;
          m_addr  = a[m_id*32 +: 32];
          m_len   = l[m_id*8 +: 8];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (rdy) begin
          if (m_cnt[m_id] < (1 << CNT_W) - 1) m_cnt[m_id]++;
          m_phase = 2;
        end
      end else if (rv && rl) begin
        m_phase = 0;
      end
    end
  endtask

  function automatic logic [127:0] rnd_addr();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] a;
    logic [31:0]  l;
    logic         rv, rl;
    int           n;
    m_phase = 0; m_last = 3; m_id = 0; m_addr = '0; m_len = '0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    rst = 1'b1; cli_req = '0; cli_addr = '0; cli_len = '0;
    cmd_rdy = 1'b0; rsp_vld = 1'b0; rsp_last = 1'b0;

    // Single request from client 2, then four beats.
    cycle(1, 4'b0000, '0, '0, 0, 0, 0);
    a = '0; a[64 +: 32] = 32'h1000;
    l = '0; l[16 +: 8] = 8'd3;
    cycle(0, 4'b0100, a, l, 0, 0, 0);
    cycle(0, 4'b0000, a, l, 0, 0, 0);
    cycle(0, 4'b0000, a, l, 1, 0, 0);
    for (int b = 0; b < 4; b++) cycle(0, 4'b0000, a, l, 0, 1, b == 3);
    cycle(0, 4'b0000, a, l, 0, 0, 0);

    // Grant order with all four requesting continuously.
    cycle(1, 4'b0000, '0, '0, 0, 0, 0);
    ack_log.delete();
    n = 0;
    while (ack_log.size() < 6 && n < 40) begin
      cycle(0, 4'b1111, rnd_addr(), $urandom(), 1, 1, 1);
      n++;
    end
    if (ack_log.size() < 6) chk("order_timeout", ack_log.size(), 6);
    else for (int k = 0; k < 6; k++) chk("order", ack_log[k], k % 4);

    // Command stall with changing addresses, then unexpected beat in IDLE.
    cycle(1, 4'b0000, '0, '0, 0, 0, 0);
    cycle(0, 4'b0001, rnd_addr(), $urandom(), 0, 0, 0);
    for (int s = 0; s < 5; s++) cycle(0, 4'b0001, rnd_addr(), $urandom(), 0, 0, 0);
    cycle(0, 4'b0001, rnd_addr(), $urandom(), 1, 0, 0);
    cycle(0, 4'b0000, rnd_addr(), $urandom(), 0, 1, 1);
    cycle(0, 4'b0000, rnd_addr(), $urandom(), 0, 1, 0);
    cycle(0, 4'b0010, rnd_addr(), $urandom(), 0, 0, 0);
    cycle(0, 4'b0000, rnd_addr(), $urandom(), 1, 0, 0);
    cycle(0, 4'b0000, rnd_addr(), $urandom(), 0, 1, 1);

    // Reset mid-burst, then 4'b1001 must go to client 0.
    cycle(0, 4'b0100, rnd_addr(), $urandom(), 0, 0, 0);
    cycle(0, 4'b0000, rnd_addr(), $urandom(), 1, 0, 0);
    cycle(0, 4'b0000, rnd_addr(), $urandom(), 0, 1, 0);
    cycle(1, 4'b0000, rnd_addr(), $urandom(), 0, 1, 0);
    cycle(0, 4'b1001, rnd_addr(), $urandom(), 0, 0, 0);
    cycle(0, 4'b0000, rnd_addr(), $urandom(), 1, 0, 0);
    cycle(0, 4'b0000, rnd_addr(), $urandom(), 0, 1, 1);

`ifdef MCIF_ARB_PERF_EN
    // Seventeen grants to client 1 saturate its 4-bit counter.
    cycle(1, 4'b0000, '0, '0, 0, 0, 0);
    for (int g = 0; g < 17 * 3 + 1; g++) cycle(0, 4'b0010, rnd_addr(), $urandom(), 1, 1, 1);
`endif

    // Random traffic with occasional resets and stray beats.
    cycle(1, 4'b0000, '0, '0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (m_phase == 2) begin
        rv = ($urandom_range(0, 9) < 6);
        rl = ($urandom_range(0, 9) < 4);
      end else begin
        rv = ($urandom_range(0, 39) == 0);
        rl = $urandom_range(0, 1);
      end
      cycle($urandom_range(0, 79) == 0, 4'($urandom()), rnd_addr(), $urandom(),
            $urandom_range(0, 2) != 0, rv, rl);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
